// File: rtl/id_decode_stage.sv
// Registered RV32 instruction-decode stage: decodes one instruction per cycle into the
// control bundle and holds it in the ID/EX register behind a valid/ready handshake.
module id_decode_stage #(
  parameter logic ENABLE_M = 1'b1,
  parameter logic RV32E    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [2:0]  id_extop,
  output logic        id_regwr,
  output logic        id_aluasrc,
  output logic        id_memtoreg,
  output logic        id_memwr,
  output logic [1:0]  id_alubsrc,
  output logic [3:0]  id_aluctr,
  output logic [2:0]  id_branch,
  output logic [2:0]  id_memop,
  output logic        id_mdu,
  output logic [2:0]  id_mduop,
  output logic        id_illegal,
  output logic [31:0] perf_bubbles
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  extop;
    logic        regwr;
    logic        aluasrc;
    logic        memtoreg;
    logic        memwr;
    logic [1:0]  alubsrc;
    logic [3:0]  aluctr;
    logic [2:0]  branch;
    logic [2:0]  memop;
    logic        mdu;
    logic [2:0]  mduop;
    logic        illegal;
  } ctrl_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_COPYB = 4'b0011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  logic [4:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      dec;
  logic       illegal_c;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       uses_rd;

  ctrl_t       ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic [31:0] bubbles_q, bubbles_d;
  logic        advance;
  logic        load_use;

  assign opc    = if_instr[6:2];
  assign funct3 = if_instr[14:12];
  assign funct7 = if_instr[31:25];

  always_comb begin
    dec       = '0;
    illegal_c = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b0;
    dec.pc    = if_pc;
    dec.rs1   = if_instr[19:15];
    dec.rs2   = if_instr[24:20];
    dec.rd    = if_instr[11:7];
    dec.memop = funct3;
    case (opc)
      OPC_LUI: begin
        dec.extop = EXT_U; dec.alubsrc = 2'b01; dec.aluctr = ALU_COPYB;
        dec.regwr = 1'b1; uses_rs1 = 1'b0; uses_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.extop = EXT_U; dec.aluasrc = 1'b1; dec.alubsrc = 2'b01; dec.aluctr = ALU_ADD;
        dec.regwr = 1'b1; uses_rs1 = 1'b0; uses_rd = 1'b1;
      end
      OPC_OPIMM: begin
        dec.extop = EXT_I; dec.alubsrc = 2'b01; dec.regwr = 1'b1; uses_rd = 1'b1;
        if (funct3 == 3'b011)      dec.aluctr = ALU_SLTU;
        else if (funct3 == 3'b101) dec.aluctr = {funct7[5], 3'b101};
        else                       dec.aluctr = {1'b0, funct3};
      end
      OPC_OP: begin
        dec.regwr = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
        dec.aluctr = (funct3 == 3'b011) ? ALU_SLTU : {funct7[5], funct3};
        if (ENABLE_M && funct7 == 7'b0000001) begin
          dec.mdu = 1'b1; dec.mduop = funct3; dec.aluctr = ALU_ADD;
        end else if (!(funct7 == 7'b0000000 ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
          illegal_c = 1'b1;
        end
      end
      OPC_JAL: begin
        dec.extop = EXT_J; dec.aluasrc = 1'b1; dec.alubsrc = 2'b10; dec.aluctr = ALU_ADD;
        dec.regwr = 1'b1; dec.branch = 3'b001; uses_rs1 = 1'b0; uses_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.extop = EXT_I; dec.aluasrc = 1'b1; dec.alubsrc = 2'b10; dec.aluctr = ALU_ADD;
        dec.regwr = 1'b1; dec.branch = 3'b010; uses_rd = 1'b1;
      end
      OPC_BRANCH: begin
        dec.extop  = EXT_B; uses_rs2 = 1'b1;
        dec.branch = {1'b1, funct3[1:0]};
        dec.aluctr = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SLT;
        if (funct3[2:1] == 2'b01) illegal_c = 1'b1;
      end
      OPC_LOAD: begin
        dec.extop = EXT_I; dec.alubsrc = 2'b01; dec.aluctr = ALU_ADD;
        dec.memtoreg = 1'b1; dec.regwr = 1'b1; uses_rd = 1'b1;
      end
      OPC_STORE: begin
        dec.extop = EXT_S; dec.alubsrc = 2'b01; dec.aluctr = ALU_ADD;
        dec.memwr = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_MISC: ;
      default: illegal_c = 1'b1;
    endcase
    if (if_instr[1:0] != 2'b11) illegal_c = 1'b1;
    // RV32E only has x0..x15, so any referenced upper register is illegal
    if (RV32E && ((uses_rs1 && dec.rs1[4]) || (uses_rs2 && dec.rs2[4]) || (uses_rd && dec.rd[4])))
      illegal_c = 1'b1;
    if (illegal_c) begin
      dec.regwr = 1'b0; dec.memwr = 1'b0; dec.memtoreg = 1'b0;
      dec.branch = 3'b000; dec.mdu = 1'b0; dec.mduop = 3'b000;
    end
    dec.illegal = illegal_c;
  end

  assign advance  = ~valid_q | ex_ready;
  assign load_use = valid_q & ctrl_q.memtoreg & (ctrl_q.rd != 5'd0) & if_valid &
                    ((uses_rs1 & (dec.rs1 == ctrl_q.rd)) | (uses_rs2 & (dec.rs2 == ctrl_q.rd)));
  assign if_ready = rst_n & (flush | (advance & ~load_use));

  // Flush beats the load-use bubble, which beats a normal advance
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    bubbles_d = bubbles_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance && load_use) begin
      valid_d = 1'b0;
      if (bubbles_q != 32'hFFFF_FFFF) bubbles_d = bubbles_q + 32'd1;
    end else if (advance) begin
      valid_d = if_valid;
      if (if_valid) ctrl_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      bubbles_q <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = ctrl_q.pc;
  assign id_rs1       = ctrl_q.rs1;
  assign id_rs2       = ctrl_q.rs2;
  assign id_rd        = ctrl_q.rd;
  assign id_extop     = ctrl_q.extop;
  assign id_regwr     = ctrl_q.regwr;
  assign id_aluasrc   = ctrl_q.aluasrc;
  assign id_memtoreg  = ctrl_q.memtoreg;
  assign id_memwr     = ctrl_q.memwr;
  assign id_alubsrc   = ctrl_q.alubsrc;
  assign id_aluctr    = ctrl_q.aluctr;
  assign id_branch    = ctrl_q.branch;
  assign id_memop     = ctrl_q.memop;
  assign id_mdu       = ctrl_q.mdu;
  assign id_mduop     = ctrl_q.mduop;
  assign id_illegal   = ctrl_q.illegal;
  assign perf_bubbles = bubbles_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: two instances (M enabled / RV32E with M disabled) driven by
// the same inputs, compared each cycle against a behavioural model plus decode tables.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  extop;
    logic        regwr;
    logic        aluasrc;
    logic        memtoreg;
    logic        memwr;
    logic [1:0]  alubsrc;
    logic [3:0]  aluctr;
    logic [2:0]  branch;
    logic [2:0]  memop;
    logic        mdu;
    logic [2:0]  mduop;
    logic        illegal;
  } fields_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  extop;
    logic        aluasrc;
    logic [1:0]  alubsrc;
    logic [3:0]  aluctr;
    logic [2:0]  branch;
    logic        regwr;
    logic        memtoreg;
    logic        memwr;
    logic        mdu;
    logic        ill_m;
    logic        ill_e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;

  logic        rdy[2], vld[2], regwr_o[2], aluasrc_o[2], memtoreg_o[2], memwr_o[2];
  logic        mdu_o[2], illegal_o[2];
  logic [31:0] pc_o[2], bub[2];
  logic [4:0]  rs1_o[2], rs2_o[2], rd_o[2];
  logic [2:0]  extop_o[2], branch_o[2], memop_o[2], mduop_o[2];
  logic [1:0]  alubsrc_o[2];
  logic [3:0]  aluctr_o[2];

  fields_t     mf[2];
  logic        mv[2];
  logic [31:0] mb[2];
  logic        last_rdy[2];
  int          checks = 0;
  int          errors = 0;
  vec_t        vec[19];

  always #5 clk = ~clk;

  id_decode_stage #(.ENABLE_M(1'b1), .RV32E(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(rdy[0]), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .id_valid(vld[0]), .id_pc(pc_o[0]),
    .id_rs1(rs1_o[0]), .id_rs2(rs2_o[0]), .id_rd(rd_o[0]), .id_extop(extop_o[0]),
    .id_regwr(regwr_o[0]), .id_aluasrc(aluasrc_o[0]), .id_memtoreg(memtoreg_o[0]),
    .id_memwr(memwr_o[0]), .id_alubsrc(alubsrc_o[0]), .id_aluctr(aluctr_o[0]),
    .id_branch(branch_o[0]), .id_memop(memop_o[0]), .id_mdu(mdu_o[0]), .id_mduop(mduop_o[0]),
    .id_illegal(illegal_o[0]), .perf_bubbles(bub[0]));

  id_decode_stage #(.ENABLE_M(1'b0), .RV32E(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(rdy[1]), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .id_valid(vld[1]), .id_pc(pc_o[1]),
    .id_rs1(rs1_o[1]), .id_rs2(rs2_o[1]), .id_rd(rd_o[1]), .id_extop(extop_o[1]),
    .id_regwr(regwr_o[1]), .id_aluasrc(aluasrc_o[1]), .id_memtoreg(memtoreg_o[1]),
    .id_memwr(memwr_o[1]), .id_alubsrc(alubsrc_o[1]), .id_aluctr(aluctr_o[1]),
    .id_branch(branch_o[1]), .id_memop(memop_o[1]), .id_mdu(mdu_o[1]), .id_mduop(mduop_o[1]),
    .id_illegal(illegal_o[1]), .perf_bubbles(bub[1]));

  function automatic fields_t act(input int i);
    return '{pc: pc_o[i], rs1: rs1_o[i], rs2: rs2_o[i], rd: rd_o[i], extop: extop_o[i],
             regwr: regwr_o[i], aluasrc: aluasrc_o[i], memtoreg: memtoreg_o[i],
             memwr: memwr_o[i], alubsrc: alubsrc_o[i], aluctr: aluctr_o[i],
             branch: branch_o[i], memop: memop_o[i], mdu: mdu_o[i], mduop: mduop_o[i],
             illegal: illegal_o[i]};
  endfunction

  // {uses rs1, uses rs2}
  function automatic logic [1:0] uses(input logic [31:0] ins);
    logic [4:0] o;
    o = ins[6:2];
    return {!(o == 5'b01101 || o == 5'b00101 || o == 5'b11011),
            (o == 5'b01100 || o == 5'b11000 || o == 5'b01000)};
  endfunction

  function automatic fields_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input bit em, input bit e);
    fields_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] u;
    bit writes, bad;
    f3 = ins[14:12]; f7 = ins[31:25]; u = uses(ins);
    r = '0; r.pc = pc; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7]; r.memop = f3;
    writes = 0; bad = (ins[1:0] != 2'b11);
    case (ins[6:2])
      5'b01101: begin r.extop = 1; r.alubsrc = 1; r.aluctr = 4'b0011; writes = 1; end
      5'b00101: begin r.extop = 1; r.aluasrc = 1; r.alubsrc = 1; writes = 1; end
      5'b00100: begin
        r.alubsrc = 1; writes = 1;
        r.aluctr = (f3 == 3) ? 4'b1010 : (f3 == 5) ? {f7[5], 3'b101} : {1'b0, f3};
      end
      5'b01100: begin
        writes = 1;
        if (em && f7 == 7'h01) begin r.mdu = 1; r.mduop = f3; end
        else begin
          r.aluctr = (f3 == 3) ? 4'b1010 : {f7[5], f3};
          if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) bad = 1;
        end
      end
      5'b11011: begin r.extop = 4; r.aluasrc = 1; r.alubsrc = 2; r.branch = 1; writes = 1; end
      5'b11001: begin r.aluasrc = 1; r.alubsrc = 2; r.branch = 2; writes = 1; end
      5'b11000: begin
        r.extop = 3; r.branch = {1'b1, f3[1:0]};
        r.aluctr = (f3 >= 6) ? 4'b1010 : 4'b0010;
        if (f3 == 2 || f3 == 3) bad = 1;
      end
      5'b00000: begin r.alubsrc = 1; r.memtoreg = 1; writes = 1; end
      5'b01000: begin r.extop = 2; r.alubsrc = 1; r.memwr = 1; end
      5'b00011: ;
      default:  bad = 1;
    endcase
    if (e && ((u[1] && r.rs1 >= 16) || (u[0] && r.rs2 >= 16) || (writes && r.rd >= 16))) bad = 1;
    r.regwr = writes;
    if (bad) begin
      r.regwr = 0; r.memwr = 0; r.memtoreg = 0; r.branch = 0; r.mdu = 0; r.mduop = 0;
    end
    r.illegal = bad;
    return r;
  endfunction

  function automatic bit hazard(input int i);
    logic [1:0] u;
    u = uses(if_instr);
    return mv[i] && mf[i].memtoreg && mf[i].rd != 0 && if_valid &&
           ((u[1] && if_instr[19:15] == mf[i].rd) || (u[0] && if_instr[24:20] == mf[i].rd));
  endfunction

  function automatic bit exp_ready(input int i);
    return rst_n && (flush || ((!mv[i] || ex_ready) && !hazard(i)));
  endfunction

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d if_ready", i), rdy[i], exp_ready(i));
      chk($sformatf("dut%0d id_valid", i), vld[i], mv[i]);
      chk($sformatf("dut%0d perf_bubbles", i), bub[i], mb[i]);
      if (mv[i]) chk($sformatf("dut%0d fields", i), act(i), mf[i]);
    end
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model with the DUT
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic fl, input logic exr, input logic rn);
    bit adv[2], lu[2];
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = exr; rst_n = rn;
    @(negedge clk);
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      last_rdy[i] = rdy[i];
      adv[i] = !mv[i] || ex_ready;
      lu[i]  = hazard(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin mv[i] = 0; mb[i] = 0; end
      else if (flush) mv[i] = 0;
      else if (adv[i] && lu[i]) begin
        mv[i] = 0;
        if (mb[i] != 32'hFFFF_FFFF) mb[i] = mb[i] + 1;
      end else if (adv[i]) begin
        mv[i] = if_valid;
        if (if_valid) mf[i] = ref_decode(if_instr, if_pc, i == 0, i == 1);
      end
    end
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 4) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    case ($urandom_range(0, 11))
      0: w[6:2] = 5'b01101;
      1: w[6:2] = 5'b00101;
      2: w[6:2] = 5'b00100;
      3, 4: w[6:2] = 5'b01100;
      5: w[6:2] = 5'b11011;
      6: w[6:2] = 5'b11001;
      7: w[6:2] = 5'b11000;
      8, 9: w[6:2] = 5'b00000;
      10: w[6:2] = 5'b01000;
      default: ;
    endcase
    w[24:20] = pick_reg(); w[19:15] = pick_reg(); w[11:7] = pick_reg();
    if ($urandom_range(0, 15) != 0) w[1:0] = 2'b11;
    return w;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            instr         ext  asrc bsrc aluctr   br      wr mtr mw mdu ill_m ill_e
    vec[0]  = '{32'h00500093, 3'd0, 0, 2'd1, 4'b0000, 3'b000, 1, 0, 0, 0, 0, 0};
    vec[1]  = '{32'h0000A103, 3'd0, 0, 2'd1, 4'b0000, 3'b000, 1, 1, 0, 0, 0, 0};
    vec[2]  = '{32'h027302B3, 3'd0, 0, 2'd0, 4'b0000, 3'b000, 1, 0, 0, 1, 0, 1};
    vec[3]  = '{32'h027342B3, 3'd0, 0, 2'd0, 4'b0000, 3'b000, 1, 0, 0, 1, 0, 1};
    vec[4]  = '{32'h00000833, 3'd0, 0, 2'd0, 4'b0000, 3'b000, 1, 0, 0, 0, 0, 1};
    vec[5]  = '{32'h00000073, 3'd0, 0, 2'd0, 4'b0000, 3'b000, 0, 0, 0, 0, 1, 1};
    vec[6]  = '{32'h40208033, 3'd0, 0, 2'd0, 4'b1000, 3'b000, 1, 0, 0, 0, 0, 0};
    vec[7]  = '{32'h123452B7, 3'd1, 0, 2'd1, 4'b0011, 3'b000, 1, 0, 0, 0, 0, 0};
    vec[8]  = '{32'h008000EF, 3'd4, 1, 2'd2, 4'b0000, 3'b001, 1, 0, 0, 0, 0, 0};
    vec[9]  = '{32'h0020E063, 3'd3, 0, 2'd0, 4'b1010, 3'b110, 0, 0, 0, 0, 0, 0};
    vec[10] = '{32'h0020A063, 3'd3, 0, 2'd0, 4'b0010, 3'b000, 0, 0, 0, 0, 1, 1};
    vec[11] = '{32'h0020A023, 3'd2, 0, 2'd1, 4'b0000, 3'b000, 0, 0, 1, 0, 0, 0};
    vec[12] = '{32'h4030D093, 3'd0, 0, 2'd1, 4'b1101, 3'b000, 1, 0, 0, 0, 0, 0};
    vec[13] = '{32'h0FF0000F, 3'd0, 0, 2'd0, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 0};
    vec[14] = '{32'h40209033, 3'd0, 0, 2'd0, 4'b1001, 3'b000, 0, 0, 0, 0, 1, 1};
    vec[15] = '{32'h00000001, 3'd0, 0, 2'd1, 4'b0000, 3'b000, 0, 0, 0, 0, 1, 1};
    vec[16] = '{32'h000280E7, 3'd0, 1, 2'd2, 4'b0000, 3'b010, 1, 0, 0, 0, 0, 0};
    vec[17] = '{32'h00001197, 3'd1, 1, 2'd1, 4'b0000, 3'b000, 1, 0, 0, 0, 0, 0};
    vec[18] = '{32'h0110D063, 3'd3, 0, 2'd0, 4'b0010, 3'b101, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 2; i++) begin mv[i] = 0; mb[i] = 0; mf[i] = '0; end
    rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_ready = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset");
    applyStimulus(1, 32'h00500093, 32'h0, 0, 1, 0);
    chk("reset if_ready c1", last_rdy[0], 0);
    applyStimulus(1, 32'h00500093, 32'h0, 0, 1, 0);
    chk("reset if_ready c2", last_rdy[0], 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    chk("reset id_valid", vld[0], 0);
    chk("reset perf_bubbles", bub[0], 0);

    $display("[TB] decode table");
    for (int k = 0; k < 19; k++) begin
      applyStimulus(1, vec[k].instr, 32'h1000 + 32'(k * 4), 0, 1, 1);
      chk($sformatf("vec%0d extop", k), extop_o[0], vec[k].extop);
      chk($sformatf("vec%0d aluasrc", k), aluasrc_o[0], vec[k].aluasrc);
      chk($sformatf("vec%0d alubsrc", k), alubsrc_o[0], vec[k].alubsrc);
      chk($sformatf("vec%0d aluctr", k), aluctr_o[0], vec[k].aluctr);
      chk($sformatf("vec%0d branch", k), branch_o[0], vec[k].branch);
      chk($sformatf("vec%0d ctl", k), {regwr_o[0], memtoreg_o[0], memwr_o[0], mdu_o[0]},
          {vec[k].regwr, vec[k].memtoreg, vec[k].memwr, vec[k].mdu});
      chk($sformatf("vec%0d illegal_m", k), illegal_o[0], vec[k].ill_m);
      chk($sformatf("vec%0d illegal_e", k), illegal_o[1], vec[k].ill_e);
      chk($sformatf("vec%0d regwr_e", k), regwr_o[1], vec[k].regwr & ~vec[k].ill_e);
      applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    end

    $display("[TB] back-to-back and load-use");
    applyStimulus(1, 32'h00500093, 32'h100, 0, 1, 1);
    chk("b2b addi", {aluctr_o[0], alubsrc_o[0], regwr_o[0], rd_o[0]}, {4'b0000, 2'b01, 1'b1, 5'd1});
    applyStimulus(1, 32'h0000A103, 32'h104, 0, 1, 1);
    chk("b2b lw", {memtoreg_o[0], memop_o[0], rd_o[0]}, {1'b1, 3'b010, 5'd2});
    applyStimulus(1, 32'h002101B3, 32'h108, 0, 1, 1);
    chk("lu if_ready stall", last_rdy[0], 0);
    chk("lu bubble valid", vld[0], 0);
    applyStimulus(1, 32'h002101B3, 32'h108, 0, 1, 1);
    chk("lu if_ready resume", last_rdy[0], 1);
    chk("lu add issued", {vld[0], rd_o[0]}, {1'b1, 5'd3});
    chk("lu perf_bubbles", bub[0], 1);

    $display("[TB] backpressure and flush");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h00500093, 32'h10C, 0, 0, 1);
      chk($sformatf("bp if_ready %0d", k), last_rdy[0], 0);
      chk($sformatf("bp held %0d", k), {vld[0], pc_o[0], rd_o[0]}, {1'b1, 32'h108, 5'd3});
    end
    applyStimulus(1, 32'h00500093, 32'h10C, 1, 0, 1);
    chk("flush if_ready", last_rdy[0], 1);
    chk("flush id_valid", vld[0], 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    chk("flush dropped", vld[0], 0);

    applyStimulus(1, 32'h0000A103, 32'h200, 0, 1, 1);
    applyStimulus(1, 32'h002101B3, 32'h204, 1, 1, 1);
    chk("flush+lu if_ready", last_rdy[0], 1);
    chk("flush+lu no bubble", {vld[0], bub[0]}, {1'b0, 32'd1});

    $display("[TB] reset mid-stream");
    applyStimulus(1, 32'h00500093, 32'h300, 0, 1, 1);
    applyStimulus(1, 32'h00500093, 32'h304, 0, 1, 0);
    chk("mid reset valid", {vld[0], bub[0]}, {1'b0, 32'd0});
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    chk("post reset valid", vld[0], 0);

    $display("[TB] random");
    for (int n = 0; n < 800; n++)
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 49) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered instruction-decode stage for the RV32 core, replacing the purely combinational control generator. It decodes one instruction per cycle into the existing control-bundle encodings and holds the result in the ID/EX pipeline register. It adds:
- a valid/ready handshake on both sides,
- one-bubble load-use hazard insertion and flush,
- illegal-instruction flagging,
- optional RV32E and M-extension modes.

## Interface
- ENABLE_M, 0, 1: decode funct7=0000001 R-type as MUL/DIV; 0: flag it illegal
- RV32E, 0, 1: any used register index ≥16 flags illegal
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  its PC
- flush  in  1  kill the instruction being accepted and the ID/EX contents
- ex_ready  in  1  EX accepts the ID/EX register this cycle
- id_valid  out  1  ID/EX register holds an instruction
- id_pc  out  32  registered PC
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_extop  out  3  I=000, U=001, S=010, B=011, J=100
- id_regwr, id_aluasrc, id_memtoreg, id_memwr  out  1 each  control bits
- id_alubsrc  out  2  00=rs2, 01=imm, 10=const 4
- id_aluctr  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, COPYB 0011
- id_branch  out  3  000 none, 001 JAL, 010 JALR, 1xx conditional with xx=funct3[1:0]
- id_memop  out  3  funct3
- id_mdu  out  1  M-extension operation
- id_mduop  out  3  funct3 when id_mdu=1
- id_illegal  out  1  illegal instruction
- perf_bubbles  out  32  saturating count of load-use bubbles

## Operation
Decode is by op[6:2]; op[1:0]≠11 is illegal.

Per-opcode decode:
- **LUI**: U, alubsrc 01, aluctr COPYB, regwr.
- **AUIPC**: U, aluasrc 1, alubsrc 01, ADD, regwr.
- **OP-IMM**: I, alubsrc 01, regwr.
  - funct3=011 → SLTU.
  - funct3=101 → {funct7[5],101}.
  - otherwise {0,funct3}.
- **OP**: alubsrc 00, regwr; aluctr={funct7[5],funct3}, except funct3=011 → SLTU.
  - funct7 must be 0000000, or 0100000 (only with funct3 000 or 101); anything else is illegal.
  - funct7=0000001 with ENABLE_M=1: id_mdu=1, id_mduop=funct3, aluctr ADD.
- **JAL**: J, aluasrc 1, alubsrc 10, ADD, regwr, branch 001.
- **JALR**: I, aluasrc 1, alubsrc 10, ADD, regwr, branch 010.
- **BRANCH**: B, branch {1,funct3[1:0]}; aluctr SLTU for funct3 11x, else SLT.
  - funct3 010/011 are illegal.
- **LOAD**: I, alubsrc 01, ADD, memtoreg, regwr.
- **STORE**: S, alubsrc 01, ADD, memwr.
- **MISC-MEM (FENCE)**: NOP, with all write/branch controls 0.
- **Any other opcode, incl. SYSTEM**: illegal.

Illegal handling:
- Sets id_illegal=1 and forces regwr, memwr, memtoreg, branch and id_mdu to 0.
- The instruction still flows with id_valid=1.

Register usage:
- rs1 is used by all opcodes except LUI, AUIPC, JAL.
- rs2 is used by OP, BRANCH and STORE only.

Handshake:
- advance = ~id_valid | ex_ready.
- load_use = id_valid & id_memtoreg & (id_rd≠0) & if_valid & ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd)).
- if_ready = rst_n & (flush | (advance & ~load_use)).

Register update, in priority order:
1. ~rst_n: all outputs 0.
2. flush: id_valid←0; the incoming word is consumed and dropped.
3. advance & load_use: id_valid←0 (bubble); perf_bubbles += 1, saturating at 0xFFFF_FFFF.
4. advance: id_valid←if_valid; when if_valid=1, all fields are loaded from the decode.
5. Otherwise: hold all outputs.

Fields are don't-care while id_valid=0, but are reset to 0.

## Timing
- Latency is 1 cycle from if_valid&if_ready to id_valid.
- Throughput is 1 instruction per cycle with no hazards.
- Load-use costs exactly 1 bubble cycle; the dependent instruction is accepted on the next cycle.
- If ex_ready=0, outputs are stable and if_ready=0, except during flush.
- Flush is acted on regardless of ex_ready.
- Flush coincident with load_use: flush wins, and perf_bubbles does not increment.
- Reset mid-stream discards the ID/EX contents; id_valid=0 on the first cycle after rst_n rises.

## Test plan
- **Reset**: hold rst_n=0 for 2 cycles with if_valid=1 → if_ready=0; after release, id_valid=0 and perf_bubbles=0.
- **Back-to-back decode**: 0x00500093 (addi x1,x0,5) then 0x0000A103 (lw x2,0(x1)), ex_ready=1.
  - Cycle 1: aluctr 0000, alubsrc 01, regwr=1, rd=1.
  - Cycle 2: memtoreg=1, memop 010, rd=2.
- **Load-use**: 0x0000A103 then 0x002101B3 (add x3,x2,x2) → one cycle with if_ready=0 and id_valid=0 next, then add issues; perf_bubbles=1.
- **Backpressure and flush**: ex_ready=0 for 3 cycles → id_* held, if_ready=0; assert flush with ex_ready=0 → id_valid=0 next cycle and the word is dropped.
- **M-extension mode**: 0x027302B3 (mul x5,x6,x7).
  - ENABLE_M=1: id_mdu=1, mduop 000, regwr=1.
  - ENABLE_M=0: id_illegal=1, regwr=0.
- **RV32E and illegal opcode**:
  - RV32E=1 with 0x00000833 (add x16,x0,x0) → id_illegal=1, regwr=0.
  - 0x00000073 (ecall) → id_illegal=1.
